otter_cu_fsm: RTL and testbench
===============================

// Module: otter_cu_fsm
// PURPOSE
//  Multicycle control sequencer for the OTTER RV32I core.
//  - Steps each instruction through fetch, execute and (for loads) writeback.
//  - Drives the write/read enables of the PC, register file, memory and CSR file.
//  - Supports a wait-state handshake on the data port, a bounded wait timeout
//    and a machine-interrupt entry state.
//  - Sits beside the decoder; its PC_WRITE/PC_RST outputs sequence the PC register.
// PARAMETERS
//  WAIT_LIMIT  16  max cycles in ST_MEMWAIT before abort (>=1)
//  USE_MEM_HS  1   1: honour MEM_READY; 0: MEM_READY treated as constant 1
// PORTS
//  CLK        in   1  sole clock, rising edge
//  RST        in   1  asynchronous, active-high reset
//  IR_OPCODE  in   7  IR[6:0] of current instruction
//  IR_FUNC3   in   3  IR[14:12]
//  INTR       in   1  external interrupt request, level
//  CSR_MIE    in   1  mstatus.MIE from CSR file
//  MEM_READY  in   1  data memory completes the current access
//  PC_RST     out  1  synchronous clear request to PC
//  PC_WRITE   out  1  PC loads PC_DIN this edge
//  REG_WRITE  out  1  register-file write enable
//  MEM_RDEN1  out  1  instruction-port read enable
//  MEM_RDEN2  out  1  data-port read enable
//  MEM_WE2    out  1  data-port write enable
//  CSR_WE     out  1  CSR write enable
//  INT_TAKEN  out  1  interrupt entry (PC mux selects mtvec; CSR saves mepc)
//  MRET_EXEC  out  1  mret executing (PC mux selects mepc)
//  ILLEGAL_OP out  1  one-cycle pulse, unrecognised opcode
//  MEM_ERR    out  1  one-cycle pulse, data access aborted on timeout
// BEHAVIOUR
//  - Outputs are combinational from the state register and IR/MEM_READY.
//  - RST high forces ST_INIT immediately, mid-instruction included.
//    Wait counter and access-type flag clear.
//    Every output is 0 except PC_RST=1.
//  - States:
//    INIT:    PC_RST=1; next FETCH (one cycle after RST falls).
//    FETCH:   MEM_RDEN1=1; next EXEC. Exactly one cycle.
//    EXEC, decode IR_OPCODE:
//      LOAD 0000011:   MEM_RDEN2=1; MEM_READY ? WB : MEMWAIT (flag=load).
//      STORE 0100011:  MEM_WE2=1; MEM_READY ? complete : MEMWAIT (flag=store).
//      BRANCH 1100011: complete, PC_WRITE only.
//      SYSTEM 1110011, func3=000 (mret): complete, MRET_EXEC=1.
//      SYSTEM, func3 001/010/011: complete, REG_WRITE=1, CSR_WE=1.
//      OP, OP-IMM, LUI, AUIPC, JAL, JALR: complete, REG_WRITE=1.
//      Any other opcode/func3: complete with no writes, ILLEGAL_OP=1.
//    MEMWAIT:
//      Holds MEM_RDEN2 (load) or MEM_WE2 (store) steady; counter increments.
//      MEM_READY=1: load -> WB; store -> complete.
//      Counter reaches WAIT_LIMIT without MEM_READY: complete with no
//      register write, MEM_ERR=1. The abort cycle asserts no enable.
//    WB:   REG_WRITE=1; complete.
//    INTR: INT_TAKEN=1, PC_WRITE=1; next FETCH. Never chains to a second INTR.
//  - "complete" means: PC_WRITE=1 this cycle; next = (INTR & CSR_MIE) ? INTR : FETCH.
//    INTR is sampled only in the completing cycle.
//  - Exactly one PC_WRITE per instruction plus one per interrupt entry.
//    PC_WRITE is never 1 in INIT, FETCH or a non-completing EXEC/MEMWAIT cycle.
//  - MEM_READY=1 and INTR in the same completing cycle: the access completes,
//    then INTR is entered.
//  - Latency, zero wait states: ALU/branch/CSR 2 cycles; load 3; store 2.
//    Each MEMWAIT cycle adds 1.
//  - Counter width $clog2(WAIT_LIMIT+1). Counter resets on entering MEMWAIT.
// STRUCTURE
//  - otter_pkg: opcode enum (opcode_t), state enum (cu_state_t), SYSTEM func3
//    constants. Shared with the decoder.
//  - One sub-module: mem_wait_timer (clear, enable, WAIT_LIMIT -> expired).
//  - Rest is a single two-process FSM.
// TESTING
//  - RST=1 mid-EXEC of a store -> same cycle all outputs 0, PC_RST=1.
//    After release: INIT(1) then FETCH, MEM_RDEN1=1.
//  - ADDI 0010011, MEM_READY=1 -> FETCH, then EXEC with PC_WRITE=1 and
//    REG_WRITE=1; 2 cycles per instruction.
//  - LW, MEM_READY low 3 cycles -> MEM_RDEN2 held 4 cycles.
//    Then WB: REG_WRITE=1, PC_WRITE=1.
//  - SW, MEM_READY never, WAIT_LIMIT=4 -> MEM_WE2 held, then MEM_ERR pulse,
//    PC_WRITE=1, REG_WRITE=0, then FETCH.
//  - INTR=1, CSR_MIE=1 during ADD EXEC -> INTR state: INT_TAKEN=1, PC_WRITE=1.
//    Then FETCH. With CSR_MIE=0 -> straight to FETCH.
//  - Opcode 1111111 -> ILLEGAL_OP pulse, PC_WRITE=1, no REG/MEM/CSR write.
//    mret (0x30200073) -> MRET_EXEC=1.

Source files
------------

// File: rtl/otter_cu_fsm_pkg.sv
// Shared OTTER control definitions: opcode and state encodings and the SYSTEM
// func3 values. The decoder uses the same package.
package otter_cu_fsm_pkg;

  localparam int OPC_W = 7;
  localparam int F3_W  = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_SYSTEM = 7'b1110011,
    OP_OP     = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_t;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_WB      = 3'd4,
    ST_INTR    = 3'd5
  } cu_state_t;

  localparam logic [F3_W-1:0] F3_MRET  = 3'b000;
  localparam logic [F3_W-1:0] F3_CSRRW = 3'b001;
  localparam logic [F3_W-1:0] F3_CSRRS = 3'b010;
  localparam logic [F3_W-1:0] F3_CSRRC = 3'b011;

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control-unit bundle: instruction fields, status inputs and enable outputs.
// slave = the sequencer, master = the datapath driving IR/status.
interface otter_cu_fsm_if;
  import otter_cu_fsm_pkg::*;

  logic [OPC_W-1:0] IR_OPCODE;
  logic [F3_W-1:0]  IR_FUNC3;
  logic             INTR;
  logic             CSR_MIE;
  logic             MEM_READY;
  logic             PC_RST;
  logic             PC_WRITE;
  logic             REG_WRITE;
  logic             MEM_RDEN1;
  logic             MEM_RDEN2;
  logic             MEM_WE2;
  logic             CSR_WE;
  logic             INT_TAKEN;
  logic             MRET_EXEC;
  logic             ILLEGAL_OP;
  logic             MEM_ERR;

  modport slave (
    input  IR_OPCODE, IR_FUNC3, INTR, CSR_MIE, MEM_READY,
    output PC_RST, PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
           CSR_WE, INT_TAKEN, MRET_EXEC, ILLEGAL_OP, MEM_ERR
  );

  modport master (
    output IR_OPCODE, IR_FUNC3, INTR, CSR_MIE, MEM_READY,
    input  PC_RST, PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
           CSR_WE, INT_TAKEN, MRET_EXEC, ILLEGAL_OP, MEM_ERR
  );

endinterface

// File: rtl/otter_cu_fsm_mem_wait_timer.sv
// Counts data-port wait cycles; expires once WAIT_LIMIT cycles have been spent
// waiting. Saturates at the limit until cleared.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            CW    = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_expired = (r_count >= LIMIT);

endmodule

// File: rtl/otter_cu_fsm.sv
// Multicycle control sequencer for the OTTER RV32I core: fetch, execute,
// optional data-port wait and load writeback, plus machine-interrupt entry.
module otter_cu_fsm
    import otter_cu_fsm_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter bit USE_MEM_HS = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    otter_cu_fsm_if.slave     cu,
    output cu_state_t         o_dbg_state
);

    cu_state_t r_state;
    cu_state_t w_state_next;
    logic      r_is_store;
    logic      w_is_store_next;
    logic      w_ready;
    logic      w_expired;
    logic      w_timer_clear;
    logic      w_timer_en;
    logic      w_complete;

    logic w_pc_rst, w_pc_write, w_reg_write, w_rden1, w_rden2, w_we2;
    logic w_csr_we, w_int_taken, w_mret, w_illegal, w_mem_err;

    assign w_ready = USE_MEM_HS ? cu.MEM_READY : 1'b1;

    mem_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_expired(w_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_INIT;
            r_is_store <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_is_store <= w_is_store_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_is_store_next = r_is_store;
        w_timer_clear   = 1'b1;
        w_timer_en      = 1'b0;
        w_complete      = 1'b0;
        w_pc_rst        = 1'b0;
        w_pc_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_rden1         = 1'b0;
        w_rden2         = 1'b0;
        w_we2           = 1'b0;
        w_csr_we        = 1'b0;
        w_int_taken     = 1'b0;
        w_mret          = 1'b0;
        w_illegal       = 1'b0;
        w_mem_err       = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_pc_rst     = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_rden1      = 1'b1;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (cu.IR_OPCODE)
                    OP_LOAD: begin
                        w_rden2         = 1'b1;
                        w_is_store_next = 1'b0;
                        w_state_next    = w_ready ? ST_WB : ST_MEMWAIT;
                    end
                    OP_STORE: begin
                        w_we2           = 1'b1;
                        w_is_store_next = 1'b1;
                        if (w_ready) w_complete = 1'b1;
                        else         w_state_next = ST_MEMWAIT;
                    end
                    OP_BRANCH: w_complete = 1'b1;
                    OP_SYSTEM: begin
                        w_complete = 1'b1;
                        if (cu.IR_FUNC3 == F3_MRET) begin
                            w_mret = 1'b1;
                        end else if (cu.IR_FUNC3 == F3_CSRRW ||
                                     cu.IR_FUNC3 == F3_CSRRS ||
                                     cu.IR_FUNC3 == F3_CSRRC) begin
                            w_reg_write = 1'b1;
                            w_csr_we    = 1'b1;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        w_reg_write = 1'b1;
                        w_complete  = 1'b1;
                    end
                    default: begin
                        w_illegal  = 1'b1;
                        w_complete = 1'b1;
                    end
                endcase
            end
            ST_MEMWAIT: begin
                w_timer_clear = 1'b0;
                // The abort cycle drops the enable so memory sees the access withdrawn.
                if (w_expired) begin
                    w_mem_err  = 1'b1;
                    w_complete = 1'b1;
                end else begin
                    w_timer_en = 1'b1;
                    w_we2      = r_is_store;
                    w_rden2    = !r_is_store;
                    if (w_ready) begin
                        if (r_is_store) w_complete = 1'b1;
                        else            w_state_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                w_reg_write = 1'b1;
                w_complete  = 1'b1;
            end
            ST_INTR: begin
                w_int_taken  = 1'b1;
                w_pc_write   = 1'b1;
                w_state_next = ST_FETCH;
            end
            default: w_state_next = ST_INIT;
        endcase

        // Interrupts are only sampled at an instruction boundary.
        if (w_complete) begin
            w_pc_write   = 1'b1;
            w_state_next = (cu.INTR && cu.CSR_MIE) ? ST_INTR : ST_FETCH;
        end
    end

    assign cu.PC_RST     = w_pc_rst;
    assign cu.PC_WRITE   = w_pc_write;
    assign cu.REG_WRITE  = w_reg_write;
    assign cu.MEM_RDEN1  = w_rden1;
    assign cu.MEM_RDEN2  = w_rden2;
    assign cu.MEM_WE2    = w_we2;
    assign cu.CSR_WE     = w_csr_we;
    assign cu.INT_TAKEN  = w_int_taken;
    assign cu.MRET_EXEC  = w_mret;
    assign cu.ILLEGAL_OP = w_illegal;
    assign cu.MEM_ERR    = w_mem_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm (WAIT_LIMIT=4): each step sets inputs after a
// rising edge and checks outputs plus state at the following falling edge.
module tb_otter_cu_fsm;
  import otter_cu_fsm_pkg::*;

  localparam logic [10:0] O_NONE  = 11'b000_0000_0000;
  localparam logic [10:0] O_PCRST = 11'b100_0000_0000;
  localparam logic [10:0] O_PCW   = 11'b010_0000_0000;
  localparam logic [10:0] O_RW    = 11'b001_0000_0000;
  localparam logic [10:0] O_RD1   = 11'b000_1000_0000;
  localparam logic [10:0] O_RD2   = 11'b000_0100_0000;
  localparam logic [10:0] O_WE2   = 11'b000_0010_0000;
  localparam logic [10:0] O_CSR   = 11'b000_0001_0000;
  localparam logic [10:0] O_INT   = 11'b000_0000_1000;
  localparam logic [10:0] O_MRET  = 11'b000_0000_0100;
  localparam logic [10:0] O_ILL   = 11'b000_0000_0010;
  localparam logic [10:0] O_MERR  = 11'b000_0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  cu_state_t   dbg_state;
  logic [10:0] outs;
  int          vectors = 0;
  int          miscompares = 0;

  otter_cu_fsm_if cu_if ();

  otter_cu_fsm #(
    .WAIT_LIMIT(4),
    .USE_MEM_HS(1'b1)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .cu         (cu_if.slave),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign outs = {cu_if.PC_RST, cu_if.PC_WRITE, cu_if.REG_WRITE, cu_if.MEM_RDEN1,
                 cu_if.MEM_RDEN2, cu_if.MEM_WE2, cu_if.CSR_WE, cu_if.INT_TAKEN,
                 cu_if.MRET_EXEC, cu_if.ILLEGAL_OP, cu_if.MEM_ERR};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [10:0] exp_o, input cu_state_t exp_s);
    vectors++;
    assert (outs === exp_o) else begin
      miscompares++;
      $error("FAIL %s outputs: observed %b expected %b", tag, outs, exp_o);
    end
    vectors++;
    assert (dbg_state === exp_s) else begin
      miscompares++;
      $error("FAIL %s state: observed %0d expected %0d", tag, dbg_state, exp_s);
    end
  endtask

  task automatic set_ir(input logic [6:0] opc, input logic [2:0] f3);
    cu_if.IR_OPCODE = opc;
    cu_if.IR_FUNC3  = f3;
  endtask

  // Checks a FETCH cycle and advances into EXEC.
  task automatic fetch_step(input string tag);
    mid();
    chk(tag, O_RD1, ST_FETCH);
    cyc();
  endtask

  initial begin
    cu_if.IR_OPCODE = 7'b0;
    cu_if.IR_FUNC3  = 3'b0;
    cu_if.INTR      = 1'b0;
    cu_if.CSR_MIE   = 1'b0;
    cu_if.MEM_READY = 1'b1;

    // Reset and release
    cyc(); cyc();
    mid(); chk("reset", O_PCRST, ST_INIT);
    cyc(); rst = 1'b0;
    mid(); chk("init_after_release", O_PCRST, ST_INIT);
    cyc();

    // ADDI, two cycles per instruction
    set_ir(7'b0010011, 3'b000);
    fetch_step("addi_fetch");
    mid(); chk("addi_exec", O_PCW | O_RW, ST_EXEC);
    cyc();
    fetch_step("addi2_fetch");

    // Store in EXEC, then reset asserted mid-cycle
    set_ir(7'b0100011, 3'b010);
    cu_if.MEM_READY = 1'b0;
    mid(); chk("sw_exec_pre_rst", O_WE2, ST_EXEC);
    rst = 1'b1;
    #1; chk("rst_mid_exec", O_PCRST, ST_INIT);
    cyc(); rst = 1'b0;
    mid(); chk("init_after_mid_rst", O_PCRST, ST_INIT);
    cyc();
    fetch_step("fetch_after_mid_rst");

    // LW with three not-ready cycles: RDEN2 held four cycles, then WB
    set_ir(7'b0000011, 3'b010);
    mid(); chk("lw_exec", O_RD2, ST_EXEC);
    cyc();
    mid(); chk("lw_wait1", O_RD2, ST_MEMWAIT);
    cyc();
    mid(); chk("lw_wait2", O_RD2, ST_MEMWAIT);
    cyc();
    cu_if.MEM_READY = 1'b1;
    mid(); chk("lw_wait3_ready", O_RD2, ST_MEMWAIT);
    cyc();
    mid(); chk("lw_wb", O_RW | O_PCW, ST_WB);
    cyc();
    fetch_step("lw_next_fetch");

    // SW never ready: four waiting cycles, then abort
    set_ir(7'b0100011, 3'b010);
    cu_if.MEM_READY = 1'b0;
    mid(); chk("sw_to_exec", O_WE2, ST_EXEC);
    cyc();
    for (int i = 0; i < 4; i++) begin
      mid(); chk($sformatf("sw_wait%0d", i), O_WE2, ST_MEMWAIT);
      cyc();
    end
    mid(); chk("sw_abort", O_PCW | O_MERR, ST_MEMWAIT);
    cyc();
    cu_if.MEM_READY = 1'b1;
    fetch_step("sw_abort_fetch");

    // ADD with interrupt enabled: enters INTR, which does not chain
    set_ir(7'b0110011, 3'b000);
    cu_if.INTR    = 1'b1;
    cu_if.CSR_MIE = 1'b1;
    mid(); chk("add_exec_intr", O_PCW | O_RW, ST_EXEC);
    cyc();
    mid(); chk("intr_entry", O_INT | O_PCW, ST_INTR);
    cyc();
    fetch_step("intr_fetch");

    // Same with MIE clear: straight back to FETCH
    cu_if.CSR_MIE = 1'b0;
    mid(); chk("add_exec_nomie", O_PCW | O_RW, ST_EXEC);
    cyc();
    cu_if.INTR = 1'b0;
    fetch_step("nomie_fetch");

    // Illegal opcode
    set_ir(7'b1111111, 3'b000);
    mid(); chk("illegal_exec", O_PCW | O_ILL, ST_EXEC);
    cyc();
    fetch_step("illegal_fetch");

    // mret (0x30200073)
    set_ir(7'b1110011, 3'b000);
    mid(); chk("mret_exec", O_PCW | O_MRET, ST_EXEC);
    cyc();
    fetch_step("mret_fetch");

    // CSRRS
    set_ir(7'b1110011, 3'b010);
    mid(); chk("csrrs_exec", O_PCW | O_RW | O_CSR, ST_EXEC);
    cyc();
    fetch_step("csr_fetch");

    // Unsupported SYSTEM func3
    set_ir(7'b1110011, 3'b101);
    mid(); chk("sys_bad_f3", O_PCW | O_ILL, ST_EXEC);
    cyc();
    fetch_step("sys_bad_fetch");

    // Zero-wait store completing together with an interrupt
    set_ir(7'b0100011, 3'b010);
    cu_if.INTR    = 1'b1;
    cu_if.CSR_MIE = 1'b1;
    mid(); chk("sw_ready_intr", O_WE2 | O_PCW, ST_EXEC);
    cyc();
    cu_if.INTR = 1'b0;
    mid(); chk("sw_intr_entry", O_INT | O_PCW, ST_INTR);
    cyc();
    fetch_step("sw_intr_fetch");

    // Zero-wait load goes straight to WB
    set_ir(7'b0000011, 3'b010);
    mid(); chk("lw_fast_exec", O_RD2, ST_EXEC);
    cyc();
    mid(); chk("lw_fast_wb", O_RW | O_PCW, ST_WB);
    cyc();
    fetch_step("lw_fast_fetch");

    // Branch writes only the PC
    set_ir(7'b1100011, 3'b000);
    mid(); chk("branch_exec", O_PCW, ST_EXEC);
    cyc();
    mid(); chk("branch_fetch", O_RD1, ST_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
